// File: rtl/pwm_ramp_ctl_if.sv
// Control/status bundle between the register block, pwm_ramp_ctl and pwm16.
// PWM_RAMP_HOLD_EN adds the hold input.
interface pwm_ramp_ctl_if #(
  parameter int DIV_WIDTH = 16
);
  logic [15:0]          target;
  logic [15:0]          step;
  logic [DIV_WIDTH-1:0] rate_div;
  logic                 load;
`ifdef PWM_RAMP_HOLD_EN
  logic                 hold;
`endif
  logic [15:0]          duty_cycle;
  logic                 busy;
  logic                 done;

  modport master (
    output target, step, rate_div, load,
`ifdef PWM_RAMP_HOLD_EN
    output hold,
`endif
    input  duty_cycle, busy, done
  );

  modport slave (
    input  target, step, rate_div, load,
`ifdef PWM_RAMP_HOLD_EN
    input  hold,
`endif
    output duty_cycle, busy, done
  );
endinterface

// File: rtl/pwm_ramp_ctl.sv
// Duty-cycle slew sequencer for pwm16: walks duty_cycle toward a loaded target in
// fixed steps every rate_div+1 clocks. Optional freeze input under PWM_RAMP_HOLD_EN.
module pwm_ramp_ctl #(
  parameter int DIV_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pwm_ramp_ctl_if.slave    bus
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          duty_q, duty_d;
  logic [15:0]          tgt_q, tgt_d;
  logic [15:0]          step_q, step_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 done_q, done_d;
  logic                 hold_w;
  logic [16:0]          diff_w;

  function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

  // Only called when the remaining distance exceeds the step, so no wrap is possible.
  function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] stp);
    if (tgt > cur) return cur + stp;
    else           return cur - stp;
  endfunction

`ifdef PWM_RAMP_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  assign diff_w = abs_diff(tgt_q, duty_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    div_d   = div_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    // A load always wins over a coincident tick; duty never moves on the load edge.
    if (bus.load) begin
      tgt_d   = bus.target;
      step_d  = bus.step;
      div_d   = bus.rate_div;
      presc_d = '0;
      if (bus.target == duty_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (state_q == RAMP) begin
      if (!hold_w) begin
        if (presc_q == div_q) begin
          presc_d = '0;
          if (step_q == 16'd0 || diff_w <= {1'b0, step_q}) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = step_toward(duty_q, tgt_q, step_q);
          end
        end else begin
          presc_d = presc_q + DIV_WIDTH'(1);
        end
      end
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      div_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.busy       = (state_q == RAMP);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctl.sv
// Directed bench for pwm_ramp_ctl: ramps, boundaries, retarget, async reset and
// (with PWM_RAMP_HOLD_EN) hold.
module tb_pwm_ramp_ctl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  pwm_ramp_ctl_if #(.DIV_WIDTH(16)) rif ();

  pwm_ramp_ctl #(.DIV_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] t, input logic [15:0] s, input logic [15:0] d);
    rif.target   = t;
    rif.step     = s;
    rif.rate_div = d;
    rif.load     = 1'b1;
    cyc();
    rif.load     = 1'b0;
  endtask

  task automatic chk3(input string tag, input logic [15:0] duty,
                      input logic busy, input logic done);
    chk({tag, ".duty"}, 32'(rif.duty_cycle), 32'(duty));
    chk({tag, ".busy"}, 32'(rif.busy), 32'(busy));
    chk({tag, ".done"}, 32'(rif.done), 32'(done));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n      = 1'b1;
    rif.target   = '0;
    rif.step     = '0;
    rif.rate_div = '0;
    rif.load     = 1'b0;
`ifdef PWM_RAMP_HOLD_EN
    rif.hold     = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #2;
    chk3("rst", 16'h0000, 1'b0, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk3("post_rst", 16'h0000, 1'b0, 1'b0);

    // Up-ramp: 0 -> 0x10, step 4, tick every 3 clocks.
    do_load(16'h0010, 16'd4, 16'd2);
    chk3("up.load", 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk3($sformatf("up.k%0d", k), 16'(4 * (k / 3)), (k < 12), (k == 12));
    end
    cyc();
    chk3("up.after", 16'h0010, 1'b0, 1'b0);

    // Down-ramp with a remainder: 0x10 -> 0x03, step 5, every clock.
    do_load(16'h0003, 16'd5, 16'd0);
    chk3("dn.load", 16'h0010, 1'b1, 1'b0);
    cyc(); chk3("dn.1", 16'h000B, 1'b1, 1'b0);
    cyc(); chk3("dn.2", 16'h0006, 1'b1, 1'b0);
    cyc(); chk3("dn.3", 16'h0003, 1'b0, 1'b1);
    cyc(); chk3("dn.4", 16'h0003, 1'b0, 1'b0);

    // step=0 jumps straight to target on the first tick.
    do_load(16'h0000, 16'd0, 16'd0);
    chk3("s0a.load", 16'h0003, 1'b1, 1'b0);
    cyc(); chk3("s0a.1", 16'h0000, 1'b0, 1'b1);

    // Top-of-range ramp must saturate at 0xFFFF, not wrap.
    do_load(16'hFFFF, 16'h8000, 16'd0);
    cyc(); chk3("hi.1", 16'h8000, 1'b1, 1'b0);
    cyc(); chk3("hi.2", 16'hFFFF, 1'b0, 1'b1);
    do_load(16'h0000, 16'd0, 16'd0);
    chk3("s0b.load", 16'hFFFF, 1'b1, 1'b0);
    cyc(); chk3("s0b.1", 16'h0000, 1'b0, 1'b1);
    cyc();
    // Target equal to current duty completes on the load edge itself.
    do_load(16'h0000, 16'd7, 16'd3);
    chk3("eq.load", 16'h0000, 1'b0, 1'b1);
    cyc(); chk3("eq.1", 16'h0000, 1'b0, 1'b0);

    // Retarget coincident with a tick: load wins, ramp reverses.
    do_load(16'h0100, 16'h0010, 16'd1);
    cyc(); chk3("rt.1", 16'h0000, 1'b1, 1'b0);
    cyc(); chk3("rt.2", 16'h0010, 1'b1, 1'b0);
    cyc(); chk3("rt.3", 16'h0010, 1'b1, 1'b0);
    cyc(); chk3("rt.4", 16'h0020, 1'b1, 1'b0);
    cyc(); chk3("rt.5", 16'h0020, 1'b1, 1'b0);
    do_load(16'h0000, 16'h0010, 16'd1);
    chk3("rt.6", 16'h0020, 1'b1, 1'b0);
    cyc(); chk3("rt.7", 16'h0020, 1'b1, 1'b0);
    cyc(); chk3("rt.8", 16'h0010, 1'b1, 1'b0);
    cyc(); chk3("rt.9", 16'h0010, 1'b1, 1'b0);
    cyc(); chk3("rt.10", 16'h0000, 1'b0, 1'b1);
    cyc(); chk3("rt.11", 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-ramp, between clock edges.
    do_load(16'h2000, 16'h1234, 16'd0);
    cyc(); chk3("ar.1", 16'h1234, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk3("ar.async", 16'h0000, 1'b0, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk3("ar.idle", 16'h0000, 1'b0, 1'b0);

`ifdef PWM_RAMP_HOLD_EN
    // Hold for 10 clocks with the prescaler at 1; resumes from 1.
    do_load(16'h0100, 16'd1, 16'd3);
    for (int k = 1; k <= 5; k++) cyc();
    chk3("hd.pre", 16'h0001, 1'b1, 1'b0);
    rif.hold = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk3($sformatf("hd.h%0d", k), 16'h0001, 1'b1, 1'b0);
    end
    rif.hold = 1'b0;
    cyc(); chk3("hd.r1", 16'h0001, 1'b1, 1'b0);
    cyc(); chk3("hd.r2", 16'h0001, 1'b1, 1'b0);
    cyc(); chk3("hd.r3", 16'h0002, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
